pads_pwr_seq: RTL

// - Sequences the output enables of the I/O pad banks once the IO supply is good (POC reports ready).
// - Staggers bank turn-on and turn-off so simultaneous switching current on the pad ring stays bounded.
// - Sits between the pad-ring power/POC cells and the core pad drivers; bank_oe gates each bank's OEN.
// - All logic runs in the core clock domain.

---
 rtl/pads_pwr_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/pads_pwr_seq.sv
// pads_pwr_seq: staggered I/O pad-bank enable sequencer gated by a filtered POC supply-good signal
module pads_pwr_seq #(
  parameter int N_BANKS  = 4,
  parameter int STAGGER  = 16,
  parameter int POC_FILT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               poc_ok,
  input  logic               en,
  input  logic               clr_fault,
  output logic [N_BANKS-1:0] bank_oe,
  output logic               pads_ready,
  output logic               busy,
  output logic               fault,
  output logic [7:0]         fault_cnt
);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int FW = $clog2(POC_FILT + 1);
  typedef enum logic [2:0] {OFF, QUAL, RAMP_UP, ON, RAMP_DN} state_t;
  state_t             state_q, state_d;
  logic               poc_m_q, poc_s_q;
  logic [SW-1:0]      stg_q, stg_d;
  logic [FW-1:0]      filt_q, filt_d;
  logic [N_BANKS-1:0] oe_q, oe_d;
  logic               fault_q, fault_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rdy_q, busy_q;
  assign bank_oe    = oe_q;
  assign pads_ready = rdy_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_cnt  = cnt_q;
  // Next state: supply qualification, staggered ramps, and immediate drop on supply loss
  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    filt_d  = filt_q;
    oe_d    = oe_q;
    fault_d = fault_q & ~clr_fault;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: if (en) begin
        state_d = QUAL;
        filt_d  = '0;
      end
      QUAL: if (!en) state_d = OFF;
      else if (!poc_s_q) filt_d = '0;
      else if (filt_q == FW'(POC_FILT - 1)) begin
        filt_d  = FW'(POC_FILT);
        stg_d   = '0;
        state_d = RAMP_UP;
      end
      else filt_d = filt_q + FW'(1);
      default: if (!poc_s_q) begin
        oe_d    = '0;
        state_d = OFF;
        if (|oe_q) begin
          fault_d = 1'b1;
          cnt_d   = cnt_q + {7'd0, cnt_q != 8'hFF};
        end
      end
      else if (state_q == RAMP_UP && en) begin
        if (stg_q == '0) begin
          oe_d    = (oe_q << 1) | N_BANKS'(1);
          stg_d   = SW'(STAGGER - 1);
          state_d = &oe_d ? ON : RAMP_UP;
        end
        else stg_d = stg_q - SW'(1);
      end
      else if (state_q == ON && en) state_d = ON;
      else if (state_q != RAMP_DN || stg_q == '0) begin
        oe_d    = oe_q >> 1;
        stg_d   = SW'(STAGGER - 1);
        state_d = |oe_d ? RAMP_DN : OFF;
      end
      else stg_d = stg_q - SW'(1);
    endcase
  end
  // State, synchroniser and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      poc_m_q <= 1'b0;
      poc_s_q <= 1'b0;
      stg_q   <= '0;
      filt_q  <= '0;
      oe_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      poc_m_q <= poc_ok;
      poc_s_q <= poc_m_q;
      stg_q   <= stg_d;
      filt_q  <= filt_d;
      oe_q    <= oe_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      rdy_q   <= state_d == ON;
      busy_q  <= state_d == RAMP_UP || state_d == RAMP_DN;
    end
  end
endmodule
